// File: rtl/avalon_rcn_pkg.sv
// -----------------------------------------------------------------------------
// avalon_rcn_pkg
// Shared constants and types for the Avalon-to-rcn arbitration slice.
//   AV_ADDR_W / AV_DATA_W / AV_BE_W : Avalon word-address, data and byte-enable
//                                     widths seen by the rcn bridge.
//   arb_state_t                     : arbiter FSM encoding (IDLE, GRANT).
// No ports (package).
// -----------------------------------------------------------------------------
package avalon_rcn_pkg;

    localparam int AV_ADDR_W = 22;
    localparam int AV_DATA_W = 32;
    localparam int AV_BE_W   = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/avalon_rcn_arb_if.sv
// -----------------------------------------------------------------------------
// avalon_rcn_arb_if
// Bundles the NUM_REQ upstream Avalon-MM master ports (m_*) and the single
// downstream Avalon-MM port toward the rcn bridge (s_*).
//   m_waitrequest   [NUM_REQ]      per-requester stall
//   m_address       [NUM_REQ*22]   requester i at [22*i+21:22*i]
//   m_write/m_read  [NUM_REQ]      per-requester commands
//   m_byteenable    [NUM_REQ*4]    per-requester byte enables
//   m_writedata     [NUM_REQ*32]   per-requester write data
//   m_readdata      [32]           shared read data
//   m_readdatavalid [NUM_REQ]      one-hot read-data strobe
//   s_*                            single-word downstream transfer
// Modports:
//   slave  : the arbiter's view (accepts the m_* side, drives the s_* side)
//   master : the environment's view (requesters plus downstream bridge)
// -----------------------------------------------------------------------------
interface avalon_rcn_arb_if #(
    parameter int NUM_REQ = 4
);
    import avalon_rcn_pkg::*;

    logic [NUM_REQ-1:0]           m_waitrequest;
    logic [NUM_REQ*AV_ADDR_W-1:0] m_address;
    logic [NUM_REQ-1:0]           m_write;
    logic [NUM_REQ-1:0]           m_read;
    logic [NUM_REQ*AV_BE_W-1:0]   m_byteenable;
    logic [NUM_REQ*AV_DATA_W-1:0] m_writedata;
    logic [AV_DATA_W-1:0]         m_readdata;
    logic [NUM_REQ-1:0]           m_readdatavalid;

    logic                         s_waitrequest;
    logic [AV_ADDR_W-1:0]         s_address;
    logic                         s_write;
    logic                         s_read;
    logic [AV_BE_W-1:0]           s_byteenable;
    logic [AV_DATA_W-1:0]         s_writedata;
    logic [AV_DATA_W-1:0]         s_readdata;
    logic                         s_readdatavalid;

    modport slave (
        output m_waitrequest, m_readdata, m_readdatavalid,
        input  m_address, m_write, m_read, m_byteenable, m_writedata,
        input  s_waitrequest, s_readdata, s_readdatavalid,
        output s_address, s_write, s_read, s_byteenable, s_writedata
    );

    modport master (
        input  m_waitrequest, m_readdata, m_readdatavalid,
        output m_address, m_write, m_read, m_byteenable, m_writedata,
        output s_waitrequest, s_readdata, s_readdatavalid,
        input  s_address, s_write, s_read, s_byteenable, s_writedata
    );

endinterface

// File: rtl/rd_route_fifo.sv
// -----------------------------------------------------------------------------
// rd_route_fifo
// Synchronous FIFO holding the requester index of each accepted read, so that
// in-order read data can be steered back to its issuer.
//   i_clk, i_rst  : clock, asynchronous active-high reset
//   i_push        : write i_push_data (ignored when full)
//   i_pop         : discard head (ignored when empty)
//   o_pop_data    : current head entry
//   o_full/o_empty: occupancy flags from the registered count
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module rd_route_fifo #(
    parameter int ENTRY_W = 2,
    parameter int DEPTH   = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_push,
    input  logic [ENTRY_W-1:0] i_push_data,
    input  logic               i_pop,
    output logic [ENTRY_W-1:0] o_pop_data,
    output logic               o_full,
    output logic               o_empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ENTRY_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               w_push_ok;
    logic               w_pop_ok;

    assign o_full     = (r_count == CNT_W'(DEPTH));
    assign o_empty    = (r_count == '0);
    assign w_push_ok  = i_push & ~o_full;
    assign w_pop_ok   = i_pop & ~o_empty;
    assign o_pop_data = r_mem[r_rd_ptr];

    always_ff @(posedge i_clk) begin
        if (w_push_ok)
            r_mem[r_wr_ptr] <= i_push_data;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok)
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop_ok)
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            // simultaneous push and pop leaves the count unchanged
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/avalon_rcn_arb.sv
// -----------------------------------------------------------------------------
// avalon_rcn_arb
// Round-robin arbiter sharing one Avalon-MM port (toward the rcn bridge) among
// NUM_REQ Avalon-MM masters, one single-word transfer per grant. Accepted reads
// record their requester in rd_route_fifo; each downstream readdatavalid pops
// the head and raises that requester's m_readdatavalid.
//   av_clk, av_rst : clock, asynchronous active-high reset
//   bus            : avalon_rcn_arb_if.slave (m_* upstream, s_* downstream)
//   err            : only with AVALON_RCN_ARB_ERR_EN defined; sticky flag for
//                    readdatavalid with no outstanding read, or a granted
//                    requester dropping its request.
// Parameters: NUM_REQ (2..8), RD_DEPTH (power of two, outstanding reads).
// -----------------------------------------------------------------------------
module avalon_rcn_arb
    import avalon_rcn_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int RD_DEPTH = 4
) (
    input  logic av_clk,
    input  logic av_rst,
`ifdef AVALON_RCN_ARB_ERR_EN
    output logic err,
`endif
    avalon_rcn_arb_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_t         r_state;
    logic [IDX_W-1:0]   r_grant;
    logic [IDX_W-1:0]   r_last_grant;

    logic [NUM_REQ-1:0] w_req;
    logic               w_granted;
    logic               w_g_rd;
    logic               w_g_wr;
    logic               w_rd_block;
    logic               w_s_read;
    logic               w_s_write;
    logic               w_accept;
    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic [IDX_W-1:0]   w_fifo_head;
    logic [NUM_REQ-1:0] w_m_waitrequest;
    logic [NUM_REQ-1:0] w_m_readdatavalid;

    // First requester after 'last', wrapping; 'last' itself has lowest priority.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                                 input logic [IDX_W-1:0]   last);
        logic [IDX_W-1:0] pick;
        int               idx;
        pick = last;
        // walk from farthest to nearest so the nearest requester wins
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = (int'(last) + k) % NUM_REQ;
            if (req[idx])
                pick = IDX_W'(idx);
        end
        return pick;
    endfunction

    assign w_req     = bus.m_read | bus.m_write;
    assign w_granted = (r_state == GRANT);
    // read wins if a requester illegally raises both
    assign w_g_rd    = bus.m_read[r_grant];
    assign w_g_wr    = bus.m_write[r_grant] & ~w_g_rd;
    // full check uses the pre-pop count: a same-cycle pop does not release it
    assign w_rd_block = w_granted & w_g_rd & w_fifo_full;
    assign w_s_read   = w_granted & w_g_rd & ~w_fifo_full;
    assign w_s_write  = w_granted & w_g_wr;
    assign w_accept   = (w_s_read | w_s_write) & ~bus.s_waitrequest;

    assign bus.s_read       = w_s_read;
    assign bus.s_write      = w_s_write;
    assign bus.s_address    = bus.m_address[AV_ADDR_W*int'(r_grant) +: AV_ADDR_W];
    assign bus.s_byteenable = bus.m_byteenable[AV_BE_W*int'(r_grant) +: AV_BE_W];
    assign bus.s_writedata  = bus.m_writedata[AV_DATA_W*int'(r_grant) +: AV_DATA_W];
    assign bus.m_readdata   = bus.s_readdata;

    always_comb begin
        w_m_waitrequest = '1;
        if (w_granted && !w_rd_block)
            w_m_waitrequest[r_grant] = bus.s_waitrequest;
    end
    assign bus.m_waitrequest = w_m_waitrequest;

    // readdatavalid with nothing outstanding is dropped
    always_comb begin
        w_m_readdatavalid = '0;
        if (bus.s_readdatavalid && !w_fifo_empty)
            w_m_readdatavalid[w_fifo_head] = 1'b1;
    end
    assign bus.m_readdatavalid = w_m_readdatavalid;

    rd_route_fifo #(
        .ENTRY_W (IDX_W),
        .DEPTH   (RD_DEPTH)
    ) u_fifo (
        .i_clk       (av_clk),
        .i_rst       (av_rst),
        .i_push      (w_accept & w_s_read),
        .i_push_data (r_grant),
        .i_pop       (bus.s_readdatavalid),
        .o_pop_data  (w_fifo_head),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty)
    );

    always_ff @(posedge av_clk or posedge av_rst) begin
        if (av_rst) begin
            r_state      <= IDLE;
            r_grant      <= '0;
            r_last_grant <= IDX_W'(NUM_REQ - 1);
        end else begin
            case (r_state)
                IDLE: begin
                    if (|w_req) begin
                        r_grant <= rr_pick(w_req, r_last_grant);
                        r_state <= GRANT;
                    end
                end
                GRANT: begin
                    if (!w_req[r_grant]) begin
                        // requester withdrew: abandon the grant, history kept
                        r_state <= IDLE;
                    end else if (w_accept) begin
                        r_last_grant <= r_grant;
                        // re-arbitrate in the accept cycle for a bubble-free handover
                        if (|w_req) begin
                            r_grant <= rr_pick(w_req, r_grant);
                            r_state <= GRANT;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef AVALON_RCN_ARB_ERR_EN
    always_ff @(posedge av_clk or posedge av_rst) begin
        if (av_rst)
            err <= 1'b0;
        else if ((bus.s_readdatavalid && w_fifo_empty) || (w_granted && !w_req[r_grant]))
            err <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_avalon_rcn_arb.sv
// -----------------------------------------------------------------------------
// tb_avalon_rcn_arb
// Directed scenarios followed by a randomized multi-master run against an
// end-to-end model: every requester tags its addresses, the downstream model
// returns data derived from the address, so a misrouted or lost read shows up
// as a data or bookkeeping mismatch at the requester that issued it.
// -----------------------------------------------------------------------------
module tb_avalon_rcn_arb;
    localparam int NR = 4;
    localparam int RD = 4;

    logic av_clk = 1'b0;
    logic av_rst;
    always #5 av_clk = ~av_clk;

    avalon_rcn_arb_if #(.NUM_REQ(NR)) bus ();
`ifdef AVALON_RCN_ARB_ERR_EN
    logic err;
`endif

    avalon_rcn_arb #(
        .NUM_REQ  (NR),
        .RD_DEPTH (RD)
    ) u_dut (
        .av_clk (av_clk),
        .av_rst (av_rst),
`ifdef AVALON_RCN_ARB_ERR_EN
        .err    (err),
`endif
        .bus    (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.m_read          = '0;
        bus.m_write         = '0;
        bus.m_address       = '0;
        bus.m_byteenable    = '0;
        bus.m_writedata     = '0;
        bus.s_waitrequest   = 1'b0;
        bus.s_readdata      = '0;
        bus.s_readdatavalid = 1'b0;
    endtask

    task automatic step();
        @(posedge av_clk);
        #1;
    endtask

    task automatic smp();
        @(negedge av_clk);
    endtask

    task automatic do_reset();
        idle_inputs();
        av_rst = 1'b1;
        step();
        step();
        av_rst = 1'b0;
    endtask

    task automatic set_req(input int i, input bit rd, input bit wr, input logic [21:0] a,
                           input logic [31:0] d, input logic [3:0] be);
        bus.m_read[i]             = rd;
        bus.m_write[i]            = wr;
        bus.m_address[22*i +: 22] = a;
        bus.m_writedata[32*i +: 32] = d;
        bus.m_byteenable[4*i +: 4]  = be;
    endtask

    function automatic logic [31:0] slv_data(input logic [21:0] a);
        return (32'(a) * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
    endfunction

    // randomized-phase state
    bit          act [NR];
    bit          is_rd [NR];
    logic [21:0] cur_addr [NR];
    logic [31:0] cur_wd [NR];
    logic [3:0]  cur_be [NR];
    int          ops_left [NR];
    int          seq [NR];
    logic [21:0] exp_q [NR][$];
    logic [21:0] slv_q [$];

    initial begin
        int exp_g [4];
        int n_acc, acc_i, rj;
        bit s_acc, all_done;
        exp_g = '{0, 2, 0, 2};

        // ---------------- reset state ----------------
        idle_inputs();
        av_rst = 1'b1;
        bus.m_read[0] = 1'b1;
        bus.s_readdatavalid = 1'b1;
        smp();
        chk("rst_mwait", bus.m_waitrequest, 4'hF);
        chk("rst_sread", bus.s_read, 1'b0);
        chk("rst_swrite", bus.s_write, 1'b0);
        chk("rst_mrdv", bus.m_readdatavalid, 4'h0);
        step();

        // ---------------- single write from requester 1 ----------------
        do_reset();
        set_req(1, 1'b0, 1'b1, 22'h000010, 32'hDEAD_BEEF, 4'hF);
        smp();
        chk("wr_arb_swrite", bus.s_write, 1'b0);
        chk("wr_arb_mwait", bus.m_waitrequest, 4'hF);
        step();
        smp();
        chk("wr_swrite", bus.s_write, 1'b1);
        chk("wr_sread", bus.s_read, 1'b0);
        chk("wr_saddr", bus.s_address, 22'h000010);
        chk("wr_sdata", bus.s_writedata, 32'hDEAD_BEEF);
        chk("wr_sbe", bus.s_byteenable, 4'hF);
        chk("wr_mwait", bus.m_waitrequest, 4'b1101);
        step();
        set_req(1, 1'b0, 1'b0, 22'h0, 32'h0, 4'h0);
        smp();
        chk("wr_done_swrite", bus.s_write, 1'b0);
        step();

        // ---------------- 0 and 2 contend, FIFO fills ----------------
        do_reset();
        set_req(0, 1'b1, 1'b0, 22'h000100, 32'h0, 4'hF);
        set_req(2, 1'b1, 1'b0, 22'h000200, 32'h0, 4'hF);
        smp();
        chk("rr_arb_sread", bus.s_read, 1'b0);
        step();
        for (int k = 0; k < 4; k++) begin
            smp();
            chk("rr_sread", bus.s_read, 1'b1);
            chk("rr_saddr", bus.s_address, (exp_g[k] == 0) ? 22'h000100 : 22'h000200);
            chk("rr_mwait", bus.m_waitrequest, 4'hF & ~(4'h1 << exp_g[k]));
            step();
        end
        smp();
        chk("rr_full_sread", bus.s_read, 1'b0);
        chk("rr_full_mwait", bus.m_waitrequest, 4'hF);
        step();

        // ---------------- requester 3: 4 reads then stall ----------------
        do_reset();
        set_req(3, 1'b1, 1'b0, 22'h000300, 32'h0, 4'hF);
        smp();
        step();
        for (int k = 0; k < 4; k++) begin
            smp();
            chk("r3_sread", bus.s_read, 1'b1);
            chk("r3_mwait", bus.m_waitrequest, 4'b0111);
            step();
        end
        smp();
        chk("r3_stall_sread", bus.s_read, 1'b0);
        chk("r3_stall_mwait", bus.m_waitrequest, 4'hF);
        step();
        bus.s_readdatavalid = 1'b1;
        bus.s_readdata      = 32'h1234_5678;
        smp();
        chk("r3_mrdv", bus.m_readdatavalid, 4'b1000);
        chk("r3_mrdata", bus.m_readdata, 32'h1234_5678);
        chk("r3_prepop_sread", bus.s_read, 1'b0);
        step();
        bus.s_readdatavalid = 1'b0;
        smp();
        chk("r3_fifth_sread", bus.s_read, 1'b1);
        chk("r3_fifth_mwait", bus.m_waitrequest, 4'b0111);
        step();

        // ---------------- reads from 0 then 2, in-order routing ----------------
        do_reset();
        set_req(0, 1'b1, 1'b0, 22'h000100, 32'h0, 4'hF);
        set_req(2, 1'b1, 1'b0, 22'h000200, 32'h0, 4'hF);
        smp();
        step();
        smp();
        chk("io_saddr0", bus.s_address, 22'h000100);
        step();
        set_req(0, 1'b0, 1'b0, 22'h0, 32'h0, 4'h0);
        smp();
        chk("io_saddr2", bus.s_address, 22'h000200);
        chk("io_sread2", bus.s_read, 1'b1);
        step();
        set_req(2, 1'b0, 1'b0, 22'h0, 32'h0, 4'h0);
        bus.s_readdatavalid = 1'b1;
        bus.s_readdata      = 32'hA;
        smp();
        chk("io_mrdv_a", bus.m_readdatavalid, 4'b0001);
        chk("io_mrdata_a", bus.m_readdata, 32'hA);
        step();
        bus.s_readdata = 32'hB;
        smp();
        chk("io_mrdv_b", bus.m_readdatavalid, 4'b0100);
        chk("io_mrdata_b", bus.m_readdata, 32'hB);
        step();

        // ---------------- readdatavalid with nothing outstanding ----------------
        bus.s_readdata = 32'hC;
        smp();
        chk("empty_mrdv", bus.m_readdatavalid, 4'h0);
        step();
        bus.s_readdatavalid = 1'b0;
`ifdef AVALON_RCN_ARB_ERR_EN
        smp();
        chk("err_set", err, 1'b1);
        step();
        step();
        smp();
        chk("err_sticky", err, 1'b1);
        step();
`endif
        // the dropped pulse must not disturb the FIFO pointers
        set_req(1, 1'b1, 1'b0, 22'h000111, 32'h0, 4'hF);
        smp();
        step();
        smp();
        chk("after_empty_sread", bus.s_read, 1'b1);
        step();
        set_req(1, 1'b0, 1'b0, 22'h0, 32'h0, 4'h0);
        bus.s_readdatavalid = 1'b1;
        bus.s_readdata      = 32'hD;
        smp();
        chk("after_empty_mrdv", bus.m_readdatavalid, 4'b0010);
        step();
        bus.s_readdatavalid = 1'b0;
`ifdef AVALON_RCN_ARB_ERR_EN
        av_rst = 1'b1;
        step();
        av_rst = 1'b0;
        smp();
        chk("err_clear", err, 1'b0);
        step();
`endif

        // ---------------- reset while granted, 2 reads outstanding ----------------
        do_reset();
        set_req(0, 1'b1, 1'b0, 22'h000100, 32'h0, 4'hF);
        set_req(1, 1'b1, 1'b0, 22'h000140, 32'h0, 4'hF);
        smp();
        step();
        smp();
        chk("mr_sread0", bus.s_read, 1'b1);
        step();
        smp();
        chk("mr_saddr1", bus.s_address, 22'h000140);
        step();
        bus.s_waitrequest = 1'b1;
        smp();
        chk("mr_granted_sread", bus.s_read, 1'b1);
        #1;
        av_rst = 1'b1;
        #1;
        chk("mr_rst_sread", bus.s_read, 1'b0);
        chk("mr_rst_mwait", bus.m_waitrequest, 4'hF);
        idle_inputs();
        step();
        av_rst = 1'b0;
        bus.s_readdatavalid = 1'b1;
        bus.s_readdata      = 32'hE;
        smp();
        chk("mr_fifo_empty", bus.m_readdatavalid, 4'h0);
        chk("mr_idle_sread", bus.s_read, 1'b0);
        step();

        // ---------------- randomized multi-master traffic ----------------
        do_reset();
        for (int i = 0; i < NR; i++) begin
            act[i] = 1'b0;
            ops_left[i] = 40;
            seq[i] = 0;
        end
        all_done = 1'b0;
        for (int cyc = 0; cyc < 6000 && !all_done; cyc++) begin
            for (int i = 0; i < NR; i++) begin
                if (!act[i] && ops_left[i] > 0 && $urandom_range(0, 2) != 0) begin
                    act[i]      = 1'b1;
                    ops_left[i] = ops_left[i] - 1;
                    is_rd[i]    = ($urandom_range(0, 2) != 0);
                    cur_addr[i] = {3'(i), 19'(seq[i])};
                    seq[i]      = seq[i] + 1;
                    cur_wd[i]   = $urandom;
                    cur_be[i]   = 4'($urandom_range(1, 15));
                end
                set_req(i, act[i] & is_rd[i], act[i] & ~is_rd[i], cur_addr[i], cur_wd[i], cur_be[i]);
            end
            bus.s_waitrequest = ($urandom_range(0, 3) == 0);
            if (slv_q.size() > 0 && $urandom_range(0, 1) == 1) begin
                bus.s_readdatavalid = 1'b1;
                bus.s_readdata      = slv_data(slv_q.pop_front());
            end else begin
                bus.s_readdatavalid = 1'b0;
                bus.s_readdata      = $urandom;
            end
            smp();
            n_acc = 0;
            acc_i = 0;
            for (int i = 0; i < NR; i++) begin
                if (act[i] && !bus.m_waitrequest[i]) begin
                    n_acc++;
                    acc_i = i;
                end
            end
            s_acc = (bus.s_read | bus.s_write) & ~bus.s_waitrequest;
            if (n_acc != 0 || s_acc)
                chk("rnd_accept_pair", 64'(n_acc), {63'd0, s_acc});
            if (s_acc && n_acc == 1) begin
                chk("rnd_saddr", bus.s_address, cur_addr[acc_i]);
                chk("rnd_kind", bus.s_read, is_rd[acc_i]);
                if (is_rd[acc_i]) begin
                    slv_q.push_back(bus.s_address);
                    exp_q[acc_i].push_back(cur_addr[acc_i]);
                end else begin
                    chk("rnd_wdata", bus.s_writedata, cur_wd[acc_i]);
                    chk("rnd_wbe", bus.s_byteenable, cur_be[acc_i]);
                end
                act[acc_i] = 1'b0;
            end
            if (bus.s_readdatavalid) begin
                rj = -1;
                for (int i = 0; i < NR; i++)
                    if (bus.m_readdatavalid[i]) rj = i;
                if ($countones(bus.m_readdatavalid) == 1 && rj >= 0 && exp_q[rj].size() > 0) begin
                    chk("rnd_rdata", bus.m_readdata, slv_data(exp_q[rj].pop_front()));
                end else begin
                    chk("rnd_route", bus.m_readdatavalid, 4'hF);
                end
            end else begin
                chk("rnd_rdv_quiet", bus.m_readdatavalid, 4'h0);
            end
            all_done = (slv_q.size() == 0);
            for (int i = 0; i < NR; i++)
                if (act[i] || ops_left[i] != 0 || exp_q[i].size() != 0) all_done = 1'b0;
            step();
        end
        chk("rnd_drained", all_done, 1'b1);
        for (int i = 0; i < NR; i++)
            chk("rnd_reads_left", 64'(exp_q[i].size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/avalon_rcn_arb.md
Name: avalon_rcn_arb

Overview:
Round-robin arbiter that shares one Avalon-MM slave port among NUM_REQ Avalon-MM masters.
Its downstream port connects directly to the avalon2rcn-style rcn bus master bridge.
Forwards one single-word transfer per grant.
Records the requester index of every accepted read in a return FIFO, so that in-order read data is steered back to the requester that issued it.

Parameters:
NUM_REQ, 4, number of upstream requesters (2..8).
RD_DEPTH, 4, max outstanding reads tracked (power of 2; matches the bridge's 4-deep read sequence space).

Ports:
av_clk  in  1  clock
av_rst  in  1  reset; asynchronous, active-high
m_waitrequest  out  NUM_REQ  per-requester stall
m_address  in  NUM_REQ*22  per-requester word address, requester i at [22*i+21:22*i]
m_write  in  NUM_REQ  per-requester write request
m_read  in  NUM_REQ  per-requester read request
m_byteenable  in  NUM_REQ*4  per-requester byte enables
m_writedata  in  NUM_REQ*32  per-requester write data
m_readdata  out  32  shared read data (copy of s_readdata)
m_readdatavalid  out  NUM_REQ  one-hot read-data strobe
s_waitrequest  in  1  downstream stall
s_address  out  22  downstream address
s_write  out  1  downstream write
s_read  out  1  downstream read
s_byteenable  out  4  downstream byte enables
s_writedata  out  32  downstream write data
s_readdata  in  32  downstream read data
s_readdatavalid  in  1  downstream read data strobe

Behaviour:
- Request: req[i] = m_read[i] | m_write[i]. Simultaneous read and write from one requester is illegal; read wins.
- Reset values:
  - state=IDLE, last_grant=NUM_REQ-1 (requester 0 has first priority).
  - FIFO empty, count=0.
  - s_read=s_write=0, m_waitrequest all 1, m_readdatavalid all 0.
- FSM IDLE:
  - All m_waitrequest=1, s_read=s_write=0.
  - If any req: grant <= first requesting index searching from last_grant+1, wrapping mod NUM_REQ; go to GRANT.
  - Arbitration costs exactly 1 cycle.
- FSM GRANT (index g):
  - s_* driven combinationally from requester g.
  - If m_read[g] and count==RD_DEPTH: s_read is forced 0 and m_waitrequest[g]=1.
  - Otherwise m_waitrequest[g]=s_waitrequest. All other m_waitrequest=1.
- Accept = (s_read|s_write) & !s_waitrequest. On accept:
  - last_grant<=g.
  - Re-arbitrate in the same cycle, excluding nothing. If another req is pending, go to GRANT with the new winner (zero bubble); else go to IDLE.
  - A requester holding req continuously therefore gets at most one transfer per round.
- If req[g] drops while in GRANT (protocol violation): go to IDLE, no transfer, last_grant unchanged.
- Read accept pushes g into the FIFO.
- s_readdatavalid pops the FIFO head h:
  - m_readdatavalid = one-hot(h) in the same cycle (combinational).
  - m_readdata = s_readdata always.
- Push and pop in the same cycle: count unchanged. The full check uses the pre-pop count (conservative, 1-cycle stall).
- s_readdatavalid with an empty FIFO: m_readdatavalid stays 0 and the data is dropped. Pointers and count are unchanged.
- Pointers wrap mod RD_DEPTH. Count is log2(RD_DEPTH)+1 bits.
- Writes never occupy the FIFO. The bridge issues no write-response toward Avalon.
- Reset mid-operation: everything returns to reset values immediately. Outstanding reads are forgotten; downstream shares the same reset.

Optional Feature:
AVALON_RCN_ARB_ERR_EN
- Defined:
  - Adds output err (1 bit, reset 0).
  - err is set sticky on s_readdatavalid with an empty FIFO, or on a requester dropping req while granted.
  - err is cleared only by av_rst.
- Undefined: no err port; both events are handled silently as above.

Decomposition:
- Shared package avalon_rcn_pkg: AV_ADDR_W=22, AV_DATA_W=32, AV_BE_W=4, FSM state encoding (IDLE, GRANT).
- Sub-module rd_route_fifo: synchronous FIFO of $clog2(NUM_REQ)-bit entries, depth RD_DEPTH, with push/pop/full/empty/count.
- The arbiter top holds the FSM, round-robin search and muxes.

Test Plan:
- Only requester 1 issues write addr 0x000010, data 0xDEADBEEF, be 0xF, with s_waitrequest=0 → s_write high 1 cycle after request; m_waitrequest[1] low that cycle; others stay high.
- Requesters 0 and 2 both hold reads continuously → grants alternate 0,2,0,2 with no idle cycle between accepts.
- Requester 3 issues 4 reads, no s_readdatavalid → 5th read stalls (s_read=0). One readdatavalid with data 0x12345678 → m_readdatavalid=4'b1000, then the 5th read is accepted.
- Reads from 0 then 2 accepted; two s_readdatavalid pulses (0xA, 0xB) → m_readdatavalid 4'b0001 then 4'b0100, with m_readdata 0xA then 0xB.
- s_readdatavalid with FIFO empty → all m_readdatavalid 0. With AVALON_RCN_ARB_ERR_EN defined, err=1 until av_rst.
- Assert av_rst while granted with 2 reads outstanding → next cycle s_read=0, count=0, all m_waitrequest=1.
